// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port block memory between the CPU bus and a DMA/video
// requester. At most one requester is granted per cycle. The grant drives the
// memory address, write data and write enable. The one-cycle-latency read data
// goes back to whichever requester issued the read.
//
// The CPU has priority. A streak counter caps the number of consecutive CPU
// grants while DMA is waiting, so DMA is served within CPU_MAX cycles.
//
// Ports
//   clock, reset        single clock; asynchronous active-high reset
//   cpu_req/we/address/o_data   CPU request side (held until cpu_ack)
//   cpu_ack             CPU granted this cycle
//   cpu_i_data/rvalid   CPU read return (cycle after a granted CPU read)
//   cpu_locked          low while a CPU request waits without a grant
//   dma_req/we/address/wdata    DMA request side (held until dma_ack)
//   dma_ack             DMA granted this cycle
//   dma_rdata/rvalid    DMA read return
//   mem_address/wdata/we        memory request side
//   mem_rdata           memory read data, valid one cycle after the address
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 8,
  parameter int CPU_MAX = 4
) (
  input  logic          clock,
  input  logic          reset,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_address,
  input  logic [DW-1:0] cpu_o_data,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_i_data,
  output logic          cpu_rvalid,
  output logic          cpu_locked,

  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_address,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_rvalid,

  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  localparam logic [7:0] STREAK_MAX = 8'(CPU_MAX);

  logic [7:0]    streak_q, streak_d;
  owner_t        rd_owner_q, rd_owner_d;
  logic [AW-1:0] last_addr_q;
  logic          grant_cpu, grant_dma;

  // ---------------------------------------------------------------------------
  // Grant. This logic is combinational from this cycle's requests and the
  // registered streak. It is forced off during reset so that the acks read 0
  // while reset is held.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first; otherwise a path that skips the assignment infers a latch.
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    if (!reset) begin
      grant_dma = dma_req & (~cpu_req | (streak_q >= STREAK_MAX));
      grant_cpu = cpu_req & ~grant_dma;
    end
  end

  assign cpu_ack    = grant_cpu;
  assign dma_ack    = grant_dma;
  assign cpu_locked = reset | ~(cpu_req & ~grant_cpu);

  // ---------------------------------------------------------------------------
  // Memory mux. On an idle cycle the address holds its last value so that the
  // memory does not see spurious address toggles.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_address = last_addr_q;
    mem_wdata   = cpu_o_data;
    mem_we      = 1'b0;
    if (grant_dma) begin
      mem_address = dma_address;
      mem_wdata   = dma_wdata;
      mem_we      = dma_we;
    end else if (grant_cpu) begin
      mem_address = cpu_address;
      mem_wdata   = cpu_o_data;
      mem_we      = cpu_we;
    end
  end

  // ---------------------------------------------------------------------------
  // Streak. This counts CPU wins while DMA is waiting. It clears as soon as
  // DMA is served or stops asking.
  // ---------------------------------------------------------------------------
  always_comb begin
    streak_d = streak_q;
    if (!dma_req || grant_dma) begin
      streak_d = 8'd0;
    end else if (grant_cpu && (streak_q < STREAK_MAX)) begin
      streak_d = streak_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read owner. This records who is owed the data that the memory returns
  // next cycle. Writes and idle cycles owe nothing.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_owner_d = OWN_NONE;
    if (grant_dma && !dma_we) begin
      rd_owner_d = OWN_DMA;
    end else if (grant_cpu && !cpu_we) begin
      rd_owner_d = OWN_CPU;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // register samples the values from before the edge.
      streak_q    <= 8'd0;
      rd_owner_q  <= OWN_NONE;
      last_addr_q <= '0;
    end else begin
      streak_q    <= streak_d;
      rd_owner_q  <= rd_owner_d;
      last_addr_q <= mem_address;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return. The memory data fans out to both requesters unregistered.
  // The owner register decides which requester sees it as valid.
  // ---------------------------------------------------------------------------
  assign cpu_rvalid = (rd_owner_q == OWN_CPU);
  assign dma_rvalid = (rd_owner_q == OWN_DMA);
  assign cpu_i_data = mem_rdata;
  assign dma_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Testbench for mem_arbiter. A small memory stub answers the DUT's memory port
// with one cycle of latency. A behavioural model keeps its own copy of memory
// and a count of CPU wins while DMA waits. Every cycle it predicts acks, memory
// controls, read returns and cpu_locked. Directed sequences pin hand-computed
// values. After them comes a randomized request phase.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW      = 16;
  localparam int DW      = 8;
  localparam int CPU_MAX = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_address;
  logic [DW-1:0] cpu_o_data;
  logic          cpu_ack, cpu_rvalid, cpu_locked;
  logic [DW-1:0] cpu_i_data;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_address;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack, dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .CPU_MAX(CPU_MAX)) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_address(cpu_address),
    .cpu_o_data (cpu_o_data),
    .cpu_ack    (cpu_ack),
    .cpu_i_data (cpu_i_data),
    .cpu_rvalid (cpu_rvalid),
    .cpu_locked (cpu_locked),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_address(dma_address),
    .dma_wdata  (dma_wdata),
    .dma_ack    (dma_ack),
    .dma_rdata  (dma_rdata),
    .dma_rvalid (dma_rvalid),
    .mem_address(mem_address),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Power-up memory contents. These are shared by the stub and the model.
  function automatic logic [7:0] init_val(input logic [15:0] a);
    if (a == 16'h1234) return 8'h5A;
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(1) == 0) return 16'($urandom_range(31));
    return 16'($urandom);
  endfunction

  // ---------------------------------------------------------------------------
  // Memory stub: one-cycle read latency
  // ---------------------------------------------------------------------------
  bit [7:0] stub_data [0:65535];
  bit       stub_wr   [0:65535];

  always @(posedge clock) begin
    if (mem_we) begin
      stub_data[mem_address] <= mem_wdata;
      stub_wr[mem_address]   <= 1'b1;
    end
    mem_rdata <= stub_wr[mem_address] ? stub_data[mem_address] : init_val(mem_address);
  end

  // ---------------------------------------------------------------------------
  // Behavioural model + per-cycle compare. This runs at the falling edge,
  // halfway between input changes and the next rising edge.
  // ---------------------------------------------------------------------------
  bit [7:0]    ref_data [0:65535];
  bit          ref_wr   [0:65535];
  int          wins      = 0;   // CPU grants since DMA started waiting
  int          exp_owner = 0;   // 0 none, 1 CPU, 2 DMA
  logic [7:0]  exp_rdata = 8'h00;
  logic [15:0] m_last    = 16'h0000;
  logic        e_cpu, e_dma, e_we;
  logic [15:0] e_addr;
  logic [7:0]  e_wd;

  always @(negedge clock) begin
    if (reset) begin
      check1("rst_cpu_ack", cpu_ack, 1'b0);
      check1("rst_dma_ack", dma_ack, 1'b0);
      check1("rst_mem_we", mem_we, 1'b0);
      check1("rst_cpu_rvalid", cpu_rvalid, 1'b0);
      check1("rst_dma_rvalid", dma_rvalid, 1'b0);
      check1("rst_cpu_locked", cpu_locked, 1'b1);
      wins      = 0;
      exp_owner = 0;
      m_last    = 16'h0000;
    end else begin
      e_dma  = dma_req && (!cpu_req || wins >= CPU_MAX);
      e_cpu  = cpu_req && !e_dma;
      e_addr = e_dma ? dma_address : (e_cpu ? cpu_address : m_last);
      e_we   = (e_dma && dma_we) || (e_cpu && cpu_we);
      e_wd   = e_dma ? dma_wdata : cpu_o_data;

      check1("cpu_ack", cpu_ack, e_cpu);
      check1("dma_ack", dma_ack, e_dma);
      check1("mem_we", mem_we, e_we);
      check("mem_address", 32'(mem_address), 32'(e_addr));
      if (e_we) check("mem_wdata", 32'(mem_wdata), 32'(e_wd));
      check1("cpu_rvalid", cpu_rvalid, exp_owner == 1);
      check1("dma_rvalid", dma_rvalid, exp_owner == 2);
      if (exp_owner == 1) check("cpu_i_data", 32'(cpu_i_data), 32'(exp_rdata));
      if (exp_owner == 2) check("dma_rdata", 32'(dma_rdata), 32'(exp_rdata));
      check1("cpu_locked", cpu_locked, !(cpu_req && !e_cpu));

      m_last = e_addr;
      if (!dma_req || e_dma) wins = 0;
      else if (e_cpu && wins < CPU_MAX) wins++;
      if (e_we) begin
        ref_data[e_addr] = e_wd;
        ref_wr[e_addr]   = 1'b1;
        exp_owner        = 0;
      end else if (e_cpu || e_dma) begin
        exp_owner = e_cpu ? 1 : 2;
        exp_rdata = ref_wr[e_addr] ? ref_data[e_addr] : init_val(e_addr);
      end else begin
        exp_owner = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cpu(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
    cpu_req = r; cpu_we = w; cpu_address = a; cpu_o_data = d;
  endtask

  task automatic set_dma(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
    dma_req = r; dma_we = w; dma_address = a; dma_wdata = d;
  endtask

  task automatic idle();
    set_cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    set_dma(1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  // Expected DMA grants for the contention sequences, written out by hand.
  bit pat_d [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  bit clr_req [8] = '{1, 1, 0, 1, 1, 1, 1, 1};
  bit clr_d   [8] = '{0, 0, 0, 0, 0, 0, 0, 1};

  logic c_got = 1'b0;
  logic d_got = 1'b0;

  initial begin
    idle();

    // Reset values
    repeat (2) @(posedge clock);
    #3;
    check("reset_mem_address", 32'(mem_address), 32'h0000);
    check1("reset_cpu_locked", cpu_locked, 1'b1);
    step();
    reset = 1'b0;

    // CPU-only read of 0x1234
    step();
    set_cpu(1'b1, 1'b0, 16'h1234, 8'h00);
    #2;
    check1("cpu_read_ack", cpu_ack, 1'b1);
    check1("cpu_read_dma_quiet", dma_ack, 1'b0);
    step();
    idle();
    #2;
    check1("cpu_read_rvalid", cpu_rvalid, 1'b1);
    check("cpu_read_data", 32'(cpu_i_data), 32'h5A);
    check1("cpu_read_dma_rvalid", dma_rvalid, 1'b0);

    // CPU write 0x0100 <- 0xC3
    step();
    set_cpu(1'b1, 1'b1, 16'h0100, 8'hC3);
    #2;
    check1("cpu_write_we", mem_we, 1'b1);
    check("cpu_write_addr", 32'(mem_address), 32'h0100);
    check("cpu_write_data", 32'(mem_wdata), 32'hC3);
    step();
    idle();
    #2;
    check1("cpu_write_no_rvalid", cpu_rvalid, 1'b0);

    // Continuous contention: C,C,C,C,D repeating
    for (int i = 0; i < 10; i++) begin
      step();
      set_cpu(1'b1, 1'b0, 16'h0010 + 16'(i), 8'h00);
      set_dma(1'b1, 1'b0, 16'h0020, 8'h00);
      #2;
      check1("pattern_dma_ack", dma_ack, pat_d[i]);
      check1("pattern_cpu_ack", cpu_ack, !pat_d[i]);
      check1("pattern_cpu_locked", cpu_locked, !pat_d[i]);
    end

    // DMA read 0x8000 then CPU read 0x0000 back to back
    step();
    idle();
    set_dma(1'b1, 1'b0, 16'h8000, 8'h00);
    #2;
    check1("b2b_dma_ack", dma_ack, 1'b1);
    step();
    idle();
    set_cpu(1'b1, 1'b0, 16'h0000, 8'h00);
    #2;
    check1("b2b_cpu_ack", cpu_ack, 1'b1);
    check1("b2b_dma_rvalid", dma_rvalid, 1'b1);
    check("b2b_dma_rdata", 32'(dma_rdata), 32'h25);
    step();
    idle();
    #2;
    check1("b2b_cpu_rvalid", cpu_rvalid, 1'b1);
    check("b2b_cpu_data", 32'(cpu_i_data), 32'hA5);
    check1("b2b_dma_rvalid_off", dma_rvalid, 1'b0);

    // dma_req dropped after 2 CPU grants: streak restarts
    for (int i = 0; i < 8; i++) begin
      step();
      set_cpu(1'b1, 1'b0, 16'h0030 + 16'(i), 8'h00);
      set_dma(clr_req[i], 1'b0, 16'h0038, 8'h00);
      #2;
      check1("streak_clear_dma_ack", dma_ack, clr_d[i]);
    end

    // Reset asserted the cycle after a granted CPU read, with streak at 3
    for (int i = 0; i < 3; i++) begin
      step();
      set_cpu(1'b1, 1'b0, 16'h0040 + 16'(i), 8'h00);
      set_dma(1'b1, 1'b0, 16'h0050, 8'h00);
      #2;
      check1("pre_reset_cpu_ack", cpu_ack, 1'b1);
    end
    step();
    idle();
    #1;
    check1("pre_reset_rvalid", cpu_rvalid, 1'b1);
    reset = 1'b1;
    #1;
    check1("mid_read_reset_rvalid", cpu_rvalid, 1'b0);
    check1("mid_read_reset_locked", cpu_locked, 1'b1);
    step();
    step();
    reset = 1'b0;
    #2;
    check1("post_reset_rvalid", cpu_rvalid, 1'b0);
    check1("post_reset_locked", cpu_locked, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      set_cpu(1'b1, 1'b0, 16'h0060 + 16'(i), 8'h00);
      set_dma(1'b1, 1'b0, 16'h0070, 8'h00);
      #2;
      check1("post_reset_dma_ack", dma_ack, pat_d[i]);
    end
    step();
    idle();

    // Randomized requests: held until ack, occasionally abandoned
    for (int i = 0; i < 3000; i++) begin
      step();
      if (!(cpu_req && !c_got && $urandom_range(15) != 0)) begin
        if ($urandom_range(2) != 0)
          set_cpu(1'b1, 1'($urandom_range(1)), rand_addr(), 8'($urandom));
        else
          set_cpu(1'b0, 1'b0, rand_addr(), 8'h00);
      end
      if (!(dma_req && !d_got && $urandom_range(15) != 0)) begin
        if ($urandom_range(2) != 0)
          set_dma(1'b1, 1'($urandom_range(1)), rand_addr(), 8'($urandom));
        else
          set_dma(1'b0, 1'b0, rand_addr(), 8'h00);
      end
      #3;
      c_got = cpu_ack;
      d_got = dma_ack;
    end

    step();
    idle();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
